// File: rtl/sram_march_tester.sv
// SRAM test controller: manual pass-through access to a single-port SRAM macro,
// plus a built-in March C- self-test reporting pass/fail, error count and first failure.
module sram_march_tester #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bg,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  input  logic              man_en,
  input  logic              man_wen,
  input  logic [ADDR_W-1:0] man_addr,
  input  logic [DATA_W-1:0] man_din,
  output logic [DATA_W-1:0] man_dout,
  output logic              mem_men,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  state_e            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic              wr_phase_q, wr_phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] bg_q, bg_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;

  logic              op_rd, op_wr, up, at_end, addr_step;
  logic [DATA_W-1:0] op_data;

  // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    wr_phase_d  = wr_phase_q;
    addr_d      = addr_q;
    bg_d        = bg_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    op_rd       = 1'b0;
    op_wr       = 1'b0;
    op_data     = '0;
    up          = (elem_q < 3'd3);
    at_end      = up ? (addr_q == ADDR_MAX) : (addr_q == '0);
    addr_step   = 1'b0;

    // Check the read issued last cycle; this is independent of the current op.
    if (cmp_valid_q && (mem_dout != cmp_exp_q)) begin
      if (err_q != ERR_MAX) err_d = err_q + 1'b1;
      if (err_q == '0) begin
        fail_addr_d = cmp_addr_q;
        fail_data_d = mem_dout ^ cmp_exp_q;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          elem_d      = 3'd0;
          wr_phase_d  = 1'b0;
          addr_d      = '0;
          bg_d        = bg;
          err_d       = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end
      S_RUN: begin
        // Elements 1-4 alternate read (phase 0) and write (phase 1) per address.
        case (elem_q)
          3'd0:    begin op_wr = 1'b1; op_data = bg_q; end
          3'd1, 3'd3: begin
            op_wr   = wr_phase_q;
            op_rd   = ~wr_phase_q;
            op_data = wr_phase_q ? ~bg_q : bg_q;
          end
          3'd2, 3'd4: begin
            op_wr   = wr_phase_q;
            op_rd   = ~wr_phase_q;
            op_data = wr_phase_q ? bg_q : ~bg_q;
          end
          default: begin op_rd = 1'b1; op_data = bg_q; end
        endcase
        if (elem_q == 3'd0 || elem_q == 3'd5) addr_step = 1'b1;
        else begin
          addr_step  = wr_phase_q;
          wr_phase_d = ~wr_phase_q;
        end
        if (addr_step) begin
          if (at_end) begin
            if (elem_q == 3'd5) state_d = S_DRAIN;
            else                elem_d  = elem_q + 3'd1;
          end
          // Leaving M2 at N-1 must start M3 at N-1; every other boundary wraps naturally.
          if (!(at_end && elem_q == 3'd2)) addr_d = up ? addr_q + 1'b1 : addr_q - 1'b1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    cmp_valid_d = op_rd;
    cmp_exp_d   = op_rd ? op_data : cmp_exp_q;
    cmp_addr_d  = op_rd ? addr_q  : cmp_addr_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      wr_phase_q  <= 1'b0;
      addr_q      <= '0;
      bg_q        <= '0;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      wr_phase_q  <= wr_phase_d;
      addr_q      <= addr_d;
      bg_q        <= bg_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign man_dout  = mem_dout;

  always_comb begin
    if (busy) begin
      mem_men  = (state_q == S_RUN);
      mem_wen  = op_wr;
      mem_ren  = op_rd;
      mem_addr = addr_q;
      mem_din  = op_data;
    end else begin
      mem_men  = man_en;
      mem_wen  = man_en & man_wen;
      mem_ren  = man_en & ~man_wen;
      mem_addr = man_addr;
      mem_din  = man_din;
    end
  end

endmodule

// File: tb/tb_sram_march_tester.sv
// Directed bench: clean, faulty and saturating BIST runs on 16-word instances,
// plus manual access on a 1024x8 instance, each against small memory models.
module tb_sram_march_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] bg = 8'h00;
  logic       man_en = 1'b0, man_wen = 1'b0;
  logic [3:0] man_addr_s = 4'h0;
  logic [7:0] man_din = 8'h00;
  logic       fault_en = 1'b0;

  // Instance A: ADDR_W=4, ERR_W=8, ideal/stuck-at memory
  logic       busy_a, done_a, pass_a, men_a, wen_a, ren_a;
  logic [7:0] err_a, fdata_a, dout_a, din_a, mdout_a;
  logic [3:0] faddr_a, addr_a;

  sram_march_tester #(.ADDR_W(4), .DATA_W(8), .ERR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bg(bg),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .fail_addr(faddr_a), .fail_data(fdata_a),
    .man_en(man_en), .man_wen(man_wen), .man_addr(man_addr_s), .man_din(man_din),
    .man_dout(mdout_a), .mem_men(men_a), .mem_wen(wen_a), .mem_ren(ren_a),
    .mem_addr(addr_a), .mem_din(din_a), .mem_dout(dout_a));

  logic [7:0] mem_a [16];
  initial for (int i = 0; i < 16; i++) mem_a[i] = 8'h00;
  always @(posedge clk) begin
    if (men_a && wen_a) mem_a[addr_a] <= din_a;
    if (men_a && ren_a)
      dout_a <= mem_a[addr_a] | ((fault_en && addr_a == 4'd5) ? 8'h01 : 8'h00);
  end

  // Instance B: ADDR_W=4, ERR_W=2, memory always reads 0x00
  logic       busy_b, done_b, pass_b, men_b, wen_b, ren_b;
  logic [1:0] err_b;
  logic [7:0] fdata_b, din_b, mdout_b;
  logic [3:0] faddr_b, addr_b;

  sram_march_tester #(.ADDR_W(4), .DATA_W(8), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bg(bg),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .fail_addr(faddr_b), .fail_data(fdata_b),
    .man_en(man_en), .man_wen(man_wen), .man_addr(man_addr_s), .man_din(man_din),
    .man_dout(mdout_b), .mem_men(men_b), .mem_wen(wen_b), .mem_ren(ren_b),
    .mem_addr(addr_b), .mem_din(din_b), .mem_dout(8'h00));

  // Instance C: default 1024x8, manual access only
  logic       start_c = 1'b0;
  logic       man_en_c = 1'b0, man_wen_c = 1'b0;
  logic [9:0] man_addr_c = 10'h0;
  logic [7:0] man_din_c = 8'h00;
  logic       busy_c, done_c, pass_c, men_c, wen_c, ren_c;
  logic [7:0] err_c, fdata_c, dout_c, din_c, mdout_c;
  logic [9:0] faddr_c, addr_c;

  sram_march_tester dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .bg(8'h00),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .fail_addr(faddr_c), .fail_data(fdata_c),
    .man_en(man_en_c), .man_wen(man_wen_c), .man_addr(man_addr_c), .man_din(man_din_c),
    .man_dout(mdout_c), .mem_men(men_c), .mem_wen(wen_c), .mem_ren(ren_c),
    .mem_addr(addr_c), .mem_din(din_c), .mem_dout(dout_c));

  logic [7:0] mem_c [1024];
  initial for (int i = 0; i < 1024; i++) mem_c[i] = 8'h00;
  always @(posedge clk) begin
    if (men_c && wen_c) mem_c[addr_c] <= din_c;
    if (men_c && ren_c) dout_c <= mem_c[addr_c];
  end

  int n_total = 0;
  int n_pass  = 0;
  int cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Launches a BIST run, checks the first op, and counts edges from the start edge to done.
  task automatic run_bist(input logic [7:0] pattern, input int extra_start, output int cycles);
    @(negedge clk);
    start = 1'b1;
    bg    = pattern;
    @(posedge clk);
    #1;
    start      = 1'b0;
    man_en     = 1'b1;
    man_wen    = 1'b1;
    man_addr_s = 4'hF;
    man_din    = 8'h33;
    check("first_op_busy", busy_a, 1'b1);
    check("first_op_addr", addr_a, 4'h0);
    check("first_op_wen",  wen_a, 1'b1);
    check("first_op_din",  din_a, pattern);
    cycles = 0;
    while (!done_a && cycles < 400) begin
      @(posedge clk);
      #1;
      cycles++;
      start = (cycles == extra_start);
    end
    start  = 1'b0;
    man_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",      busy_a, 1'b0);
    check("rst_done",      done_a, 1'b0);
    check("rst_pass",      pass_a, 1'b0);
    check("rst_err_count", err_a, 8'h00);
    check("rst_fail_addr", faddr_a, 4'h0);
    check("rst_mem_men",   men_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean run, bg=0x00; instance B saturates in parallel
    run_bist(8'h00, 0, cyc);
    check("clean0_cycles", cyc, 161);
    check("clean0_pass",   pass_a, 1'b1);
    check("clean0_err",    err_a, 8'h00);
    check("sat_err",       err_b, 2'd3);
    check("sat_fail_addr", faddr_b, 4'h0);
    check("sat_fail_data", fdata_b, 8'hFF);
    check("sat_pass",      pass_b, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("done_held", done_a, 1'b1);

    // Reset 100 cycles into a run
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("midrun_busy", busy_a, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rstmid_busy",  busy_a, 1'b0);
    check("rstmid_done",  done_a, 1'b0);
    check("rstmid_men",   men_a, 1'b0);
    check("rstmid_err_b", err_b, 2'd0);

    // Clean run bg=0x5A with an ignored start pulse mid-run
    run_bist(8'h5A, 50, cyc);
    check("clean5a_cycles", cyc, 161);
    check("clean5a_pass",   pass_a, 1'b1);
    check("clean5a_err",    err_a, 8'h00);

    // Stuck-at-1 on bit0 of address 5
    fault_en = 1'b1;
    run_bist(8'h00, 0, cyc);
    fault_en = 1'b0;
    check("stuck_cycles",    cyc, 161);
    check("stuck_pass",      pass_a, 1'b0);
    check("stuck_err",       err_a, 8'd3);
    check("stuck_fail_addr", faddr_a, 4'h5);
    check("stuck_fail_data", fdata_a, 8'h01);

    // Manual write then read on the 1024x8 instance
    @(negedge clk);
    man_en_c   = 1'b1;
    man_wen_c  = 1'b1;
    man_addr_c = 10'h3FF;
    man_din_c  = 8'hA5;
    #1;
    check("man_wr_men",  men_c, 1'b1);
    check("man_wr_wen",  wen_c, 1'b1);
    check("man_wr_ren",  ren_c, 1'b0);
    check("man_wr_addr", addr_c, 10'h3FF);
    check("man_wr_din",  din_c, 8'hA5);
    @(negedge clk);
    man_wen_c = 1'b0;
    man_din_c = 8'h00;
    #1;
    check("man_rd_ren", ren_c, 1'b1);
    check("man_rd_wen", wen_c, 1'b0);
    @(posedge clk);
    #1;
    check("man_dout", mdout_c, 8'hA5);
    man_en_c = 1'b0;
    #1;
    check("man_idle_men", men_c, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_march_tester.md
# sram_march_tester

Parametrised SRAM test controller that sits between the chip-level pins and a single-port synchronous SRAM macro. It has two modes. In manual mode it gives direct read/write access to the macro. In BIST mode it runs a built-in March C- sequence over the whole address space. The BIST reports pass/fail, a saturating error count and the first failing address and bit mask. It generalises the earlier fixed 1024x8 manual-only test wrapper to any depth and width, and adds self-test.

## Interface
- ADDR_W, default 10: SRAM address width; depth N = 2^ADDR_W.
- DATA_W, default 8: SRAM word width.
- ERR_W, default 8: error counter width.

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  BIST start; sampled only when busy=0
- bg  in  DATA_W  background pattern; "0" = bg, "1" = ~bg; sampled at start
- busy  out  1  BIST running
- done  out  1  BIST finished; held until next accepted start
- pass  out  1  done && err_count==0
- err_count  out  ERR_W  mismatching reads, saturating at 2^ERR_W-1
- fail_addr  out  ADDR_W  address of first mismatch
- fail_data  out  DATA_W  actual XOR expected at first mismatch
- man_en, man_wen  in  1 each  manual access enable / write select
- man_addr  in  ADDR_W  manual address
- man_din  in  DATA_W  manual write data
- man_dout  out  DATA_W  equals mem_dout (combinational)
- mem_men, mem_wen, mem_ren  out  1 each  SRAM enable / write / read
- mem_addr  out  ADDR_W  SRAM address
- mem_din  out  DATA_W  SRAM write data
- mem_dout  in  DATA_W  SRAM read data, valid the cycle after the read edge

## Operation
- **Reset values:** busy, done, pass and mem_men are 0; err_count, fail_addr and fail_data are 0; FSM is in IDLE.
- **Manual path (busy=0):**
  - mem_men = man_en.
  - mem_wen = man_en & man_wen.
  - mem_ren = man_en & ~man_wen.
  - mem_addr = man_addr; mem_din = man_din.
  - All are combinational pass-through.
  - While busy=1, all man_* inputs are ignored.
- **FSM states:** IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE -> RUN on start. This clears err_count, fail_*, done and pass, and latches bg.
  - RUN -> DRAIN after the last op of M5.
  - DRAIN -> DONE after one cycle.
  - start while in RUN or DRAIN is ignored.
- **March elements, executed in order (D0 = bg, D1 = ~bg):**
  - M0: up, w D0.
  - M1: up, r D0 then w D1.
  - M2: up, r D1 then w D0.
  - M3: down, r D0 then w D1.
  - M4: down, r D1 then w D0.
  - M5: down, r D0.
  - "Up" runs address 0..N-1; "down" runs N-1..0.
  - In M1–M4, the read and write of an address take two consecutive cycles.
- **Op timing:** one memory op per cycle, with mem_men=1 throughout RUN. Total is 10·N op cycles.
- **Compare pipeline:**
  - Each read registers expected data, address and a valid flag.
  - On the next edge, mem_dout is compared against the expected value.
  - Compares are independent of the next op, so the final M5 read is checked in DRAIN.
- **Mismatch handling:**
  - err_count increments unless saturated.
  - If err_count was 0 before the increment, fail_addr and fail_data are captured.
  - Later mismatches never overwrite fail_addr or fail_data.
- **Address counter:** ADDR_W bits, wrapping naturally. Element boundaries are detected at N-1 for up elements and 0 for down elements.
- **Reset mid-run:** returns to IDLE with all outputs at their reset values. No partial results are kept.

## Timing
- **start:** accepted at edge E0. busy=1 after E0, and the first op (M0 w, addr 0) occurs in cycle E0..E1.
- **Completion:** the last op is in cycle 10N-1..10N. DRAIN compare happens at edge E(10N+1). After that edge, busy=0, done=1 and pass is valid.
- **Example:** ADDR_W=4 gives done at E161.
- **Manual read:** a read issued at edge k gives man_dout valid after edge k, to be sampled by the external user at edge k+1.
- **Result stability:** err_count, fail_* and pass are stable from done until the next accepted start.

## Test plan
- **Reset:** rst_n=0 for 2 cycles -> busy=done=pass=0, err_count=0, fail_addr=0, mem_men=0.
- **Clean run:** ideal memory model, ADDR_W=4, bg=0x00, start pulse -> done rises exactly 161 cycles after the start edge; pass=1, err_count=0. Repeat with bg=0x5A -> same result.
- **Stuck-at fault:** model bit0 at addr 5 stuck-at-1, bg=0x00 -> pass=0, err_count=3 (M1, M3, M5 reads), fail_addr=5, fail_data=0x01.
- **Saturation:** ERR_W=2, memory always returns 0x00, bg=0x00 -> 2N=32 failing D1 reads; err_count=3, fail_addr=0 (M2 first read), fail_data=0xFF.
- **Manual access:** busy=0, write 0xA5 to addr 0x3FF, then read 0x3FF -> man_dout=0xA5 one cycle after the read edge. During BIST, man_en=1 has no effect on mem_*.
- **Disturbances:** rst_n low at cycle 100 of a run -> IDLE, busy=0, results cleared; a subsequent start completes normally. A start pulse mid-run is ignored and does not change done timing.
